// File: rtl/y_rx_pkg.sv
// Shared types and helpers for the Y-side receive console.
package y_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_HOLD
  } state_t;

  // Bits needed to count 0..v-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces a raw board input; emits a one-cycle pulse
// on each debounced rising edge.
module btn_debounce
  import y_rx_pkg::*;
#(
  parameter int unsigned DB_CNT = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_raw,
  output logic btn_db,
  output logic press
);

  localparam int unsigned CW = clog2(DB_CNT);

  logic          sync1;
  logic          btn_s;
  logic          db_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1  <= 1'b0;
      btn_s  <= 1'b0;
      btn_db <= 1'b0;
      db_q   <= 1'b0;
      press  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= btn_raw;
      btn_s <= sync1;
      // Accept the new level on the DB_CNT-th consecutive differing cycle.
      if (btn_s == btn_db) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CNT - 1)) begin
        btn_db <= btn_s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      db_q  <= btn_db;
      press <= btn_db & ~db_q;
    end
  end

endmodule

// File: rtl/y_rx_console.sv
// Button-driven pop console for the four Y egress ports: one debounced press
// pops one word from the selected port; last word and pop count kept per port.
module y_rx_console
  import y_rx_pkg::*;
#(
  parameter int unsigned DW     = 4,
  parameter int unsigned DB_CNT = 50000,
  parameter int unsigned CNTW   = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_button,
  input  logic [1:0]      switch,
  input  logic [DW-1:0]   Y_dat_o_0,
  input  logic [DW-1:0]   Y_dat_o_1,
  input  logic [DW-1:0]   Y_dat_o_2,
  input  logic [DW-1:0]   Y_dat_o_3,
  input  logic            Y_validrx_0,
  input  logic            Y_validrx_1,
  input  logic            Y_validrx_2,
  input  logic            Y_validrx_3,
  output logic            Y_ackrx_0,
  output logic            Y_ackrx_1,
  output logic            Y_ackrx_2,
  output logic            Y_ackrx_3,
  output logic [DW-1:0]   LED,
  output logic [3:0]      valids,
  output logic [CNTW-1:0] count_o,
  output logic            miss_o
);

  logic            btn_db;
  logic            press;
  state_t          state;
  state_t          state_nxt;
  logic [1:0]      sel;
  logic [3:0]      vld;
  logic [3:0]      ack;
  logic [DW-1:0]   dat  [4];
  logic [DW-1:0]   last [4];
  logic [CNTW-1:0] cnt  [4];

  btn_debounce #(.DB_CNT(DB_CNT)) u_db (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_raw (push_button),
    .btn_db  (btn_db),
    .press   (press)
  );

  assign dat[0] = Y_dat_o_0;
  assign dat[1] = Y_dat_o_1;
  assign dat[2] = Y_dat_o_2;
  assign dat[3] = Y_dat_o_3;
  assign vld    = {Y_validrx_3, Y_validrx_2, Y_validrx_1, Y_validrx_0};
  assign valids = {Y_validrx_0, Y_validrx_1, Y_validrx_2, Y_validrx_3};

  always_comb begin
    state_nxt = state;
    ack       = '0;
    case (state)
      ST_IDLE: if (press) state_nxt = vld[switch] ? ST_ACK : ST_HOLD;
      ST_ACK: begin
        ack[sel]  = 1'b1;
        state_nxt = ST_HOLD;
      end
      ST_HOLD: if (!btn_db) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_IDLE;
      sel    <= '0;
      miss_o <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        last[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && press) begin
        sel <= switch;
        if (!vld[switch]) miss_o <= 1'b1;
      end
      if (state == ST_ACK) begin
        last[sel] <= dat[sel];
        cnt[sel]  <= cnt[sel] + CNTW'(1);
        miss_o    <= 1'b0;
      end
    end
  end

  assign Y_ackrx_0 = ack[0];
  assign Y_ackrx_1 = ack[1];
  assign Y_ackrx_2 = ack[2];
  assign Y_ackrx_3 = ack[3];
  assign LED       = last[switch];
  assign count_o   = cnt[switch];

endmodule

// File: tb/tb_y_rx_console.sv
// Directed bench for y_rx_console with DB_CNT=4, CNTW=3.
module tb_y_rx_console;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       push_button;
  logic [1:0] switch;
  logic [3:0] dat [4];
  logic [3:0] v;
  logic       a0, a1, a2, a3;
  logic [3:0] led;
  logic [3:0] valids;
  logic [2:0] count_o;
  logic       miss_o;
  logic [3:0] ackv;

  assign ackv = {a3, a2, a1, a0};

  y_rx_console #(.DW(4), .DB_CNT(4), .CNTW(3)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_button (push_button),
    .switch      (switch),
    .Y_dat_o_0   (dat[0]),
    .Y_dat_o_1   (dat[1]),
    .Y_dat_o_2   (dat[2]),
    .Y_dat_o_3   (dat[3]),
    .Y_validrx_0 (v[0]),
    .Y_validrx_1 (v[1]),
    .Y_validrx_2 (v[2]),
    .Y_validrx_3 (v[3]),
    .Y_ackrx_0   (a0),
    .Y_ackrx_1   (a1),
    .Y_ackrx_2   (a2),
    .Y_ackrx_3   (a3),
    .LED         (led),
    .valids      (valids),
    .count_o     (count_o),
    .miss_o      (miss_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] sw;
    logic [3:0] vmask;
    logic [3:0] data;
    logic [3:0] exp_ack;
    logic [3:0] exp_led;
    logic [2:0] exp_cnt;
    logic       exp_miss;
  } vec_t;

  int vec_n  = 0;
  int miss_n = 0;
  int ack_seen [4];
  int first_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_acks();
    for (int i = 0; i < 4; i++) ack_seen[i] = 0;
    first_ack = -1;
  endtask

  task automatic sample_acks(input int c);
    for (int i = 0; i < 4; i++) if (ackv[i]) ack_seen[i]++;
    if (ackv != 4'b0 && first_ack < 0) first_ack = c;
  endtask

  // Called at a negedge: hold the button high for hi cycles then release
  // long enough for HOLD to exit. Optionally moves switch in the ack cycle.
  task automatic do_press(input int hi, input int sw_on_ack);
    clear_acks();
    push_button = 1'b1;
    for (int c = 1; c <= hi + 16; c++) begin
      @(negedge clk_i);
      sample_acks(c);
      if (sw_on_ack >= 0 && first_ack == c) switch = 2'(sw_on_ack);
      if (c == hi) push_button = 1'b0;
    end
  endtask

  function automatic logic [3:0] ack_mask();
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (ack_seen[i] == 1);
    for (int i = 0; i < 4; i++) if (ack_seen[i] > 1) m = 4'hF;
    return m;
  endfunction

  vec_t tbl [12];

  initial begin
    tbl[0] = '{2'd1, 4'b0101, 4'h7, 4'b0000, 4'h0, 3'd0, 1'b1};
    tbl[1] = '{2'd1, 4'b0111, 4'h5, 4'b0010, 4'h5, 3'd1, 1'b0};
    for (int i = 0; i < 9; i++)
      tbl[2+i] = '{2'd3, 4'b1000, 4'(i + 1), 4'b1000, 4'(i + 1), 3'((i + 1) % 8), 1'b0};
    tbl[11] = '{2'd3, 4'b0000, 4'hE, 4'b0000, 4'h9, 3'd1, 1'b1};

    rst_i = 1'b0;
    push_button = 1'b0;
    switch = 2'd0;
    v = 4'b0;
    for (int i = 0; i < 4; i++) dat[i] = 4'h0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    chk("reset_ack",   32'(ackv),    32'h0);
    chk("reset_led",   32'(led),     32'h0);
    chk("reset_count", 32'(count_o), 32'h0);
    chk("reset_miss",  32'(miss_o),  32'h0);
    v = 4'b0010;
    #1 chk("valids_order", 32'(valids), 32'b0100);

    // Single pop on port 2 with ack latency check.
    switch = 2'd2; v = 4'b0100; dat[2] = 4'hA;
    do_press(10, -1);
    chk("single_first_ack", 32'(first_ack), 32'd8);
    chk("single_ack_mask",  32'(ack_mask()), 32'b0100);
    chk("single_led",       32'(led),     32'hA);
    chk("single_count",     32'(count_o), 32'd1);
    chk("single_miss",      32'(miss_o),  32'd0);

    // Bounce: level never stable for DB_CNT cycles.
    clear_acks();
    for (int i = 0; i < 20; i++) begin
      push_button = ((i / 2) % 2 == 0);
      @(negedge clk_i);
      sample_acks(i);
    end
    push_button = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      sample_acks(i);
    end
    chk("bounce_no_ack", 32'(ack_mask()), 32'b0000);
    chk("bounce_count",  32'(count_o),    32'd1);
    do_press(20, -1);
    chk("long_hold_ack",   32'(ack_mask()), 32'b0100);
    chk("long_hold_count", 32'(count_o),    32'd2);

    // Select change during the ack cycle: pop stays on port 0.
    switch = 2'd0; v = 4'b0001; dat[0] = 4'h3;
    do_press(10, 3);
    chk("midsel_ack",    32'(ack_mask()), 32'b0001);
    chk("midsel_led3",   32'(led),        32'h0);
    chk("midsel_count3", 32'(count_o),    32'd0);
    switch = 2'd0;
    #1;
    chk("midsel_led0",   32'(led),        32'h3);
    chk("midsel_count0", 32'(count_o),    32'd1);

    // Empty port, refill, port-3 counter wrap, miss after wrap.
    for (int k = 0; k < 12; k++) begin
      switch = tbl[k].sw;
      v = tbl[k].vmask;
      dat[tbl[k].sw] = tbl[k].data;
      #1 chk($sformatf("tbl%0d_valids", k), 32'(valids),
             32'({tbl[k].vmask[0], tbl[k].vmask[1], tbl[k].vmask[2], tbl[k].vmask[3]}));
      do_press(10, -1);
      chk($sformatf("tbl%0d_ack", k),   32'(ack_mask()), 32'(tbl[k].exp_ack));
      chk($sformatf("tbl%0d_led", k),   32'(led),        32'(tbl[k].exp_led));
      chk($sformatf("tbl%0d_count", k), 32'(count_o),    32'(tbl[k].exp_cnt));
      chk($sformatf("tbl%0d_miss", k),  32'(miss_o),     32'(tbl[k].exp_miss));
    end

    // Async reset in the ack cycle on port 2 (last=A, cnt=2, miss set).
    switch = 2'd2; v = 4'b0100; dat[2] = 4'hC;
    push_button = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk_i);
        if (a2) seen = 1'b1;
      end
      chk("rst_ack_reached", 32'(seen), 32'd1);
    end
    #2 rst_i = 1'b0;
    #1;
    chk("rst_ack_drop", 32'(ackv),    32'h0);
    chk("rst_led",      32'(led),     32'h0);
    chk("rst_count",    32'(count_o), 32'd0);
    chk("rst_miss",     32'(miss_o),  32'd0);
    push_button = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_hold_ack", 32'(ackv),    32'h0);
    chk("rst_hold_led", 32'(led),     32'h0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("post_rst_count", 32'(count_o), 32'd0);
    chk("post_rst_miss",  32'(miss_o),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule
